// File: rtl/seq_code_monitor_if.sv
// Code-stream / match-event bundle for seq_code_monitor.
// The master drives codes, pattern, clr and evt_ready; the slave is the monitor.
interface seq_code_monitor_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       code;
   logic [WIDTH-1:0] pattern;
   logic             evt_valid;
   logic             evt_ready;
   logic [WIDTH-1:0] evt_window;
   logic [CNT_W-1:0] match_cnt;
   logic             ovf;

   modport master (
      output clr, in_valid, code, pattern, evt_ready,
      input  in_ready, evt_valid, evt_window, match_cnt, ovf
   );

   modport slave (
      input  clr, in_valid, code, pattern, evt_ready,
      output in_ready, evt_valid, evt_window, match_cnt, ovf
   );
endinterface

// File: rtl/seq_code_monitor.sv
// Decodes 2-bit select codes to bits, shifts them into a window and reports pattern matches.
// SEQ_CODE_MONITOR_SAT_EN: saturating match counter with sticky ovf (default: wrapping, ovf = 0).
//
// state   | meaning
// S_FILL  | fewer than WIDTH bits accepted since reset/clr
// S_RUN   | window full, no event pending
// S_STALL | event pending on evt_valid, waiting for evt_ready
module seq_code_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic                clk,
   input logic                rst_n,
   seq_code_monitor_if.slave  bus
);

   localparam int FW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_FILL, S_RUN, S_STALL} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] window_q, window_d;
   logic             hold_q, hold_d;
   logic [FW-1:0]    fill_left_q, fill_left_d;
   logic [WIDTH-1:0] evt_window_q, evt_window_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

   logic             in_ready;
   logic             accept;
   logic             dec_bit;
   logic [WIDTH-1:0] window_nxt;
   logic             fill_done;
   logic             compare;
   logic             hit;

   assign in_ready   = !bus.clr && (state_q != S_STALL || bus.evt_ready);
   assign accept     = bus.in_valid && in_ready;
   assign window_nxt = {window_q[WIDTH-2:0], dec_bit};
   // fill_left is a down-counter; the accept seen at terminal count 1 completes the window
   assign fill_done  = (fill_left_q == FW'(1));
   assign compare    = accept && (state_q != S_FILL || fill_done);
   assign hit        = compare && (window_nxt == bus.pattern);

   always_comb begin
      dec_bit = 1'b0;
      case (bus.code)
         2'b00:   dec_bit = 1'b0;
         2'b01:   dec_bit = 1'b1;
         2'b10:   dec_bit = 1'b0;
         default: dec_bit = hold_q;
      endcase
   end

`ifdef SEQ_CODE_MONITOR_SAT_EN
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d      = state_q;
      window_d     = window_q;
      hold_d       = hold_q;
      fill_left_d  = fill_left_q;
      evt_window_d = evt_window_q;
      match_cnt_d  = match_cnt_q;
`ifdef SEQ_CODE_MONITOR_SAT_EN
      ovf_d        = ovf_q;
`endif
      if (bus.clr) begin
         state_d     = S_FILL;
         window_d    = '0;
         hold_d      = 1'b0;
         fill_left_d = FW'(WIDTH);
         match_cnt_d = '0;
`ifdef SEQ_CODE_MONITOR_SAT_EN
         ovf_d       = 1'b0;
`endif
      end else begin
         if (accept) begin
            window_d = window_nxt;
            hold_d   = dec_bit;
            if (state_q == S_FILL)
               fill_left_d = fill_left_q - FW'(1);
         end
         if (hit) begin
            evt_window_d = window_nxt;
`ifdef SEQ_CODE_MONITOR_SAT_EN
            if (&match_cnt_q)
               ovf_d = 1'b1;
            else
               match_cnt_d = match_cnt_q + CNT_W'(1);
`else
            match_cnt_d = match_cnt_q + CNT_W'(1);
`endif
         end
         case (state_q)
            S_FILL: begin
               if (accept && fill_done)
                  state_d = hit ? S_STALL : S_RUN;
            end
            S_RUN: begin
               if (hit)
                  state_d = S_STALL;
            end
            S_STALL: begin
               // a consume and a fresh match on the same edge keeps the event up
               if (bus.evt_ready)
                  state_d = hit ? S_STALL : S_RUN;
            end
            default: state_d = S_FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FILL;
         window_q     <= '0;
         hold_q       <= 1'b0;
         fill_left_q  <= FW'(WIDTH);
         evt_window_q <= '0;
         match_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         window_q     <= window_d;
         hold_q       <= hold_d;
         fill_left_q  <= fill_left_d;
         evt_window_q <= evt_window_d;
         match_cnt_q  <= match_cnt_d;
      end
   end

`ifdef SEQ_CODE_MONITOR_SAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else
         ovf_q <= ovf_d;
   end
   assign bus.ovf = ovf_q;
`else
   assign bus.ovf = 1'b0;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.evt_valid  = (state_q == S_STALL);
   assign bus.evt_window = evt_window_q;
   assign bus.match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_seq_code_monitor.sv
// Bench for seq_code_monitor (WIDTH=4, CNT_W=2): per-cycle model compare plus directed literal checks.
module tb_seq_code_monitor;

   localparam int W    = 4;
   localparam int CW   = 2;
   localparam int CMAX = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   seq_code_monitor_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   seq_code_monitor #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
      end
   endtask

   // Model: bit history since reset/clr, event latch and an integer match count.
   int m_nbits  = 0;
   bit m_hold   = 0;
   int m_win    = 0;
   bit m_pend   = 0;
   int m_evtwin = 0;
   int m_cnt    = 0;
   bit m_ovf    = 0;
   bit m_acc, m_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_nbits = 0; m_hold = 0; m_win = 0; m_pend = 0;
         m_evtwin = 0; m_cnt = 0; m_ovf = 0;
      end else if (bus.clr) begin
         m_nbits = 0; m_hold = 0; m_win = 0; m_pend = 0;
         m_cnt = 0; m_ovf = 0;
      end else begin
         m_acc = bus.in_valid && (!m_pend || bus.evt_ready);
         if (m_pend && bus.evt_ready) m_pend = 0;
         if (m_acc) begin
            m_b = (bus.code == 2'b11) ? m_hold : (bus.code == 2'b01);
            m_hold = m_b;
            m_win = ((m_win << 1) | int'(m_b)) & ((1 << W) - 1);
            if (m_nbits < W) m_nbits++;
            if (m_nbits == W && m_win == int'(bus.pattern)) begin
               m_pend = 1;
               m_evtwin = m_win;
`ifdef SEQ_CODE_MONITOR_SAT_EN
               if (m_cnt == CMAX) m_ovf = 1;
               else m_cnt++;
`else
               m_cnt = (m_cnt + 1) % (CMAX + 1);
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready",   bus.in_ready,   !bus.clr && (!m_pend || bus.evt_ready));
      chk("evt_valid",  bus.evt_valid,  m_pend);
      chk("evt_window", bus.evt_window, m_evtwin);
      chk("match_cnt",  bus.match_cnt,  m_cnt);
      chk("ovf",        bus.ovf,        m_ovf);
   end

   task automatic cyc(input logic v, input logic [1:0] c, input logic er);
      bus.in_valid  = v;
      bus.code      = c;
      bus.evt_ready = er;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [1:0] codes_t1 [4] = '{2'b01, 2'b00, 2'b01, 2'b11};
   logic [1:0] codes_t4 [6] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10};

   initial begin
      bus.clr = 1'b0; bus.in_valid = 1'b0; bus.code = 2'b00;
      bus.pattern = '0; bus.evt_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready",   bus.in_ready,   1);
      chk("rst evt_valid",  bus.evt_valid,  0);
      chk("rst evt_window", bus.evt_window, 0);
      chk("rst match_cnt",  bus.match_cnt,  0);
      chk("rst ovf",        bus.ovf,        0);
      rst_n = 1'b1;

      // basic decode, first compare on the completing accept
      bus.pattern = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, codes_t1[i], 1'b1);
         if (i < 3) chk("t1 no early evt", bus.evt_valid, 0);
      end
      chk("t1 evt_valid",  bus.evt_valid,  1);
      chk("t1 evt_window", bus.evt_window, 4'b1011);
      chk("t1 match_cnt",  bus.match_cnt,  1);
      cyc(1'b0, 2'b00, 1'b1);

      // hold bit starts at 0
      do_reset();
      bus.pattern = 4'b0000;
      repeat (4) cyc(1'b1, 2'b11, 1'b1);
      chk("t2 evt_valid",  bus.evt_valid,  1);
      chk("t2 evt_window", bus.evt_window, 4'b0000);
      chk("t2 match_cnt",  bus.match_cnt,  1);
      bus.pattern = 4'b1111;
      cyc(1'b1, 2'b01, 1'b1);
      chk("t2 consumed", bus.evt_valid, 0);
      repeat (3) cyc(1'b1, 2'b11, 1'b1);
      chk("t2 hold evt_window", bus.evt_window, 4'b1111);
      chk("t2 hold match_cnt",  bus.match_cnt,  2);

      // backpressure
      do_reset();
      bus.pattern = 4'b1011;
      for (int i = 0; i < 4; i++) cyc(1'b1, codes_t1[i], 1'b0);
      chk("t3 evt_valid", bus.evt_valid, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 2'b01, 1'b0);
         chk("t3 stall in_ready",   bus.in_ready,   0);
         chk("t3 stall evt_window", bus.evt_window, 4'b1011);
         chk("t3 stall match_cnt",  bus.match_cnt,  1);
      end
      bus.pattern = 4'b0111;
      cyc(1'b1, 2'b01, 1'b1);
      chk("t3 reload evt_valid",  bus.evt_valid,  1);
      chk("t3 reload evt_window", bus.evt_window, 4'b0111);
      chk("t3 reload match_cnt",  bus.match_cnt,  2);
      cyc(1'b0, 2'b00, 1'b1);

      // overlapping matches
      do_reset();
      bus.pattern = 4'b1010;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, codes_t4[i], 1'b1);
         if (i == 3) chk("t4 evt at 4", bus.evt_valid, 1);
         if (i == 4) chk("t4 none at 5", bus.evt_valid, 0);
      end
      chk("t4 evt at 6",    bus.evt_valid,  1);
      chk("t4 evt_window",  bus.evt_window, 4'b1010);
      chk("t4 match_cnt",   bus.match_cnt,  2);

      // clr during a pending event
      bus.clr = 1'b1; bus.in_valid = 1'b1; bus.code = 2'b01; bus.evt_ready = 1'b0;
      #1;
      chk("t5 clr in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      bus.clr = 1'b0; bus.in_valid = 1'b0;
      chk("t5 clr evt_valid", bus.evt_valid, 0);
      chk("t5 clr match_cnt", bus.match_cnt, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, codes_t4[i], 1'b1);
         chk("t5 refill no evt", bus.evt_valid, 0);
      end
      cyc(1'b1, 2'b00, 1'b1);
      chk("t5 refill evt",  bus.evt_valid, 1);
      chk("t5 refill cnt",  bus.match_cnt, 1);

      // counter wrap / saturation, then reset mid-stream
      do_reset();
      bus.pattern = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 2'b00, 1'b1);
         if (i == 6) begin
`ifdef SEQ_CODE_MONITOR_SAT_EN
            chk("t6 cnt after 4th", bus.match_cnt, 3);
            chk("t6 ovf after 4th", bus.ovf, 1);
`else
            chk("t6 cnt after 4th", bus.match_cnt, 0);
            chk("t6 ovf after 4th", bus.ovf, 0);
`endif
         end
      end
`ifdef SEQ_CODE_MONITOR_SAT_EN
      chk("t6 cnt after 5th", bus.match_cnt, 3);
      chk("t6 ovf after 5th", bus.ovf, 1);
`else
      chk("t6 cnt after 5th", bus.match_cnt, 1);
      chk("t6 ovf after 5th", bus.ovf, 0);
`endif
      bus.in_valid = 1'b1; bus.code = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("t6 rst in_ready",   bus.in_ready,   1);
      chk("t6 rst evt_valid",  bus.evt_valid,  0);
      chk("t6 rst evt_window", bus.evt_window, 0);
      chk("t6 rst match_cnt",  bus.match_cnt,  0);
      chk("t6 rst ovf",        bus.ovf,        0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
